// File: rtl/debouncer_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM encoding and counter sizing.
package debouncer_pkg;

   typedef enum logic [1:0] {
      S_LOW   = 2'd0,
      S_CHK_H = 2'd1,
      S_HIGH  = 2'd2,
      S_CHK_L = 2'd3
   } state_t;

   // Bits needed to hold any count from 0 up to and including max_val.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/debouncer_ch.sv
// One debouncer channel: input synchroniser, stability-window FSM, hold counter
// for long-press detection, and registered level/pulse/busy outputs.
module debouncer_ch
   import debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = 1000,
   parameter int SYNC_STAGES   = 2,
   parameter int LONG_CYCLES   = 50000,
   parameter int CNT_W         = 16
) (
   input  logic clk,
   input  logic rst_a_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall,
   output logic long_hit,
   output logic busy
);

   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   s_s;
   state_t                 state_r, state_nxt_s;
   logic [CNT_W-1:0]       stab_cnt_r, stab_nxt_s;
   logic [CNT_W-1:0]       hold_cnt_r, hold_nxt_s;
   logic                   level_r, level_nxt_s;
   logic                   rise_r, rise_nxt_s;
   logic                   fall_r, fall_nxt_s;
   logic                   long_r, long_nxt_s;
   logic                   busy_r, busy_nxt_s;

   assign s_s = sync_r[SYNC_STAGES-1];

   // Synchroniser chain for the raw asynchronous input.
   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      end
   end

   // Next-state, counter and output decode for the stability FSM.
   always_comb begin
      state_nxt_s = state_r;
      stab_nxt_s  = stab_cnt_r;
      hold_nxt_s  = hold_cnt_r;
      level_nxt_s = level_r;
      rise_nxt_s  = 1'b0;
      fall_nxt_s  = 1'b0;
      long_nxt_s  = 1'b0;
      case (state_r)
         S_LOW: begin
            level_nxt_s = 1'b0;
            if (s_s) begin
               state_nxt_s = S_CHK_H;
               stab_nxt_s  = CNT_ONE;
            end else begin
               stab_nxt_s  = '0;
            end
         end
         S_CHK_H: begin
            if (!s_s) begin
               state_nxt_s = S_LOW;
               stab_nxt_s  = '0;
            end else if (stab_cnt_r == STAB_LAST) begin
               state_nxt_s = S_HIGH;
               stab_nxt_s  = '0;
               hold_nxt_s  = '0;
               level_nxt_s = 1'b1;
               rise_nxt_s  = 1'b1;
            end else begin
               stab_nxt_s  = stab_cnt_r + CNT_ONE;
            end
         end
         S_HIGH: begin
            level_nxt_s = 1'b1;
            // Saturating hold count; the pulse marks the single step onto the limit.
            if (hold_cnt_r < LONG_MAX) begin
               hold_nxt_s = hold_cnt_r + CNT_ONE;
               long_nxt_s = (hold_cnt_r == LONG_LAST);
            end else begin
               hold_nxt_s = hold_cnt_r;
            end
            if (!s_s) begin
               state_nxt_s = S_CHK_L;
               stab_nxt_s  = CNT_ONE;
            end else begin
               stab_nxt_s  = '0;
            end
         end
         S_CHK_L: begin
            if (s_s) begin
               state_nxt_s = S_HIGH;
               stab_nxt_s  = '0;
            end else if (stab_cnt_r == STAB_LAST) begin
               state_nxt_s = S_LOW;
               stab_nxt_s  = '0;
               hold_nxt_s  = '0;
               level_nxt_s = 1'b0;
               fall_nxt_s  = 1'b1;
            end else begin
               stab_nxt_s  = stab_cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = S_LOW;
            stab_nxt_s  = '0;
            hold_nxt_s  = '0;
            level_nxt_s = 1'b0;
         end
      endcase
      busy_nxt_s = (state_nxt_s == S_CHK_H) || (state_nxt_s == S_CHK_L);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         state_r    <= S_LOW;
         stab_cnt_r <= '0;
         hold_cnt_r <= '0;
         level_r    <= 1'b0;
         rise_r     <= 1'b0;
         fall_r     <= 1'b0;
         long_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         stab_cnt_r <= stab_nxt_s;
         hold_cnt_r <= hold_nxt_s;
         level_r    <= level_nxt_s;
         rise_r     <= rise_nxt_s;
         fall_r     <= fall_nxt_s;
         long_r     <= long_nxt_s;
         busy_r     <= busy_nxt_s;
      end
   end

   assign level    = level_r;
   assign rise     = rise_r;
   assign fall     = fall_r;
   assign long_hit = long_r;
   assign busy     = busy_r;

endmodule

// File: rtl/debouncer_multi.sv
// N independent debouncer channels; bit i of every vector port belongs to channel i.
module debouncer_multi
   import debouncer_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int STABLE_CYCLES = 1000,
   parameter int SYNC_STAGES   = 2,
   parameter int LONG_CYCLES   = 50000
) (
   input  logic            clk,
   input  logic            rst_a_n,
   input  logic [N_CH-1:0] debouncer_in,
   output logic [N_CH-1:0] debouncer_out,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse,
   output logic [N_CH-1:0] long_pulse,
   output logic [N_CH-1:0] busy
);

   localparam int CNT_W = cnt_width(LONG_CYCLES);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debouncer_ch #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .SYNC_STAGES   (SYNC_STAGES),
         .LONG_CYCLES   (LONG_CYCLES),
         .CNT_W         (CNT_W)
      ) u_ch (
         .clk      (clk),
         .rst_a_n  (rst_a_n),
         .din      (debouncer_in[i]),
         .level    (debouncer_out[i]),
         .rise     (rise_pulse[i]),
         .fall     (fall_pulse[i]),
         .long_hit (long_pulse[i]),
         .busy     (busy[i])
      );
   end

endmodule
